// File: rtl/scoreboard_digit_sched.sv
// Two-player BCD scoreboard: vblank-only round-robin score updates plus
// beam-position to digit/glyph-row/glyph-column mapping for the digit renderer.
module scoreboard_digit_sched #(
    parameter int unsigned BAND_ROW    = 1,
    parameter int unsigned VBLANK_LINE = 240,
    parameter bit          LEAD_BLANK  = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] hpos,
    input  logic [8:0] vpos,
    input  logic       display_on,
    input  logic [1:0] inc_req,
    input  logic       clr,
    output logic [3:0] digit,
    output logic [2:0] line,
    output logic [2:0] xofs,
    output logic       pix_en,
    output logic [1:0] inc_ack,
    output logic [1:0] inc_drop,
    output logic [7:0] score0,
    output logic [7:0] score1
);

    localparam int unsigned NPLAYER = 2;
    localparam int unsigned DIG_W   = 4;
    localparam int unsigned SCORE_W = 2 * DIG_W;
    localparam int unsigned POS_W   = 9;
    localparam int unsigned COL_W   = 8;

    localparam logic [DIG_W-1:0]   BLANK     = 4'hF;
    localparam logic [DIG_W-1:0]   DIGIT_MAX = 4'd9;
    localparam logic [SCORE_W-1:0] SCORE_MAX = 8'h99;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ONES = 2'd1,
        TENS = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic                              gnt_q, gnt_d;
    logic                              rr_q, rr_d;
    logic [NPLAYER-1:0]                pend_q, pend_d;
    logic [NPLAYER-1:0][SCORE_W-1:0]   score_q, score_d;
    logic [NPLAYER-1:0]                ack_q, ack_d;
    logic [NPLAYER-1:0]                drop_q, drop_d;

    logic [DIG_W-1:0]                  digit_q, digit_c;
    logic [2:0]                        line_q;
    logic [2:0]                        xofs_q;
    logic                              pix_en_q;

    logic                              vblank_c;
    logic                              grant_c;
    logic [NPLAYER-1:0]                busy_c;
    logic [SCORE_W-1:0]                cur_c;
    logic [COL_W-1:0]                  col_c;
    logic                              in_band_c;

    assign vblank_c = (vpos >= POS_W'(VBLANK_LINE));

    // Round-robin grant: rr breaks ties, a lone pending player always wins.
    assign grant_c = (&pend_q) ? rr_q : pend_q[1];

    // Score of the player currently owning the update sequence.
    assign cur_c = score_q[gnt_q];

    // Player whose update is in flight; its new requests are coalesced.
    always_comb begin
        busy_c = '0;
        for (int p = 0; p < int'(NPLAYER); p++) begin
            busy_c[p] = (state_q != IDLE) && (gnt_q == 1'(p));
        end
    end

    // Next-state, score update, pending capture, ack/drop generation.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        pend_d  = pend_q;
        score_d = score_q;
        ack_d   = '0;
        drop_d  = '0;

        unique case (state_q)
            IDLE: begin
                if (vblank_c && (|pend_q)) begin
                    gnt_d   = grant_c;
                    state_d = ONES;
                end
            end
            ONES: begin
                if (cur_c == SCORE_MAX) begin
                    state_d        = DONE;
                    ack_d[gnt_q]   = 1'b1;
                end else if (cur_c[DIG_W-1:0] == DIGIT_MAX) begin
                    score_d[gnt_q][DIG_W-1:0] = '0;
                    state_d                   = TENS;
                end else begin
                    score_d[gnt_q][DIG_W-1:0] = cur_c[DIG_W-1:0] + DIG_W'(1);
                    state_d                   = DONE;
                    ack_d[gnt_q]              = 1'b1;
                end
            end
            TENS: begin
                score_d[gnt_q][SCORE_W-1:DIG_W] = cur_c[SCORE_W-1:DIG_W] + DIG_W'(1);
                state_d                         = DONE;
                ack_d[gnt_q]                    = 1'b1;
            end
            DONE: begin
                pend_d[gnt_q] = 1'b0;
                rr_d          = ~gnt_q;
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        for (int p = 0; p < int'(NPLAYER); p++) begin
            if (inc_req[p]) begin
                if (pend_q[p] || busy_c[p]) begin
                    drop_d[p] = 1'b1;
                end else begin
                    pend_d[p] = 1'b1;
                end
            end
        end

        if (clr) begin
            state_d = IDLE;
            pend_d  = '0;
            score_d = '0;
            ack_d   = '0;
            drop_d  = '0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Scores, arbitration state and handshake pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt_q   <= 1'b0;
            rr_q    <= 1'b0;
            pend_q  <= '0;
            score_q <= '0;
            ack_q   <= '0;
            drop_q  <= '0;
        end else begin
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            pend_q  <= pend_d;
            score_q <= score_d;
            ack_q   <= ack_d;
            drop_q  <= drop_d;
        end
    end

    // Column bits above the pixel-pair bit: [2:0] glyph column, [6:3] slot, [7] right half.
    assign col_c     = COL_W'(hpos >> 1);
    assign in_band_c = (vpos[8:4] == 5'(BAND_ROW)) && !col_c[7];

    // Slot to digit selection from the live score registers.
    always_comb begin
        digit_c = BLANK;
        if (in_band_c) begin
            unique case (col_c[6:3])
                4'd0: digit_c = (LEAD_BLANK && (score_q[0][SCORE_W-1:DIG_W] == '0))
                                ? BLANK : score_q[0][SCORE_W-1:DIG_W];
                4'd1: digit_c = score_q[0][DIG_W-1:0];
                4'd4: digit_c = (LEAD_BLANK && (score_q[1][SCORE_W-1:DIG_W] == '0))
                                ? BLANK : score_q[1][SCORE_W-1:DIG_W];
                4'd5: digit_c = score_q[1][DIG_W-1:0];
                default: digit_c = BLANK;
            endcase
        end
    end

    // Render outputs registered together so they stay aligned.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digit_q  <= BLANK;
            line_q   <= '0;
            xofs_q   <= '0;
            pix_en_q <= 1'b0;
        end else begin
            digit_q  <= digit_c;
            line_q   <= vpos[3:1];
            xofs_q   <= col_c[2:0];
            pix_en_q <= display_on;
        end
    end

    assign digit    = digit_q;
    assign line     = line_q;
    assign xofs     = xofs_q;
    assign pix_en   = pix_en_q;
    assign inc_ack  = ack_q;
    assign inc_drop = drop_q;
    assign score0   = score_q[0];
    assign score1   = score_q[1];

endmodule

// File: tb/tb_scoreboard_digit_sched.sv
// Self-checking bench for scoreboard_digit_sched: render-path vector table with
// an expected-value queue, plus sequences for increment, carry, arbitration,
// coalescing, clear and reset corner cases.
module tb_scoreboard_digit_sched;

    logic       clk;
    logic       reset;
    logic [8:0] hpos;
    logic [8:0] vpos;
    logic       display_on;
    logic [1:0] inc_req;
    logic       clr;
    logic [3:0] digit;
    logic [2:0] line;
    logic [2:0] xofs;
    logic       pix_en;
    logic [1:0] inc_ack;
    logic [1:0] inc_drop;
    logic [7:0] score0;
    logic [7:0] score1;

    int checks = 0;
    int errors = 0;

    logic [7:0] sc_m [2];

    typedef struct {
        logic [8:0] hpos;
        logic [8:0] vpos;
        logic       on;
        logic [3:0] digit;
        logic [2:0] line;
        logic [2:0] xofs;
        logic       pix;
    } vec_t;

    typedef struct {
        logic [3:0] digit;
        logic [2:0] line;
        logic [2:0] xofs;
        logic       pix;
    } exp_t;

    vec_t vecs [12];
    exp_t exp_q [$];

    scoreboard_digit_sched dut (
        .clk        (clk),
        .reset      (reset),
        .hpos       (hpos),
        .vpos       (vpos),
        .display_on (display_on),
        .inc_req    (inc_req),
        .clr        (clr),
        .digit      (digit),
        .line       (line),
        .xofs       (xofs),
        .pix_en     (pix_en),
        .inc_ack    (inc_ack),
        .inc_drop   (inc_drop),
        .score0     (score0),
        .score1     (score1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] score_of(input int p);
        return (p == 0) ? score0 : score1;
    endfunction

    // Reference increment via integer arithmetic, saturating at 99.
    function automatic logic [7:0] bcd_inc(input logic [7:0] s);
        int v;
        v = int'(s[7:4]) * 10 + int'(s[3:0]);
        if (v < 99) v = v + 1;
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    // Request-to-ack cycles: 3 normally, 4 when the ones digit carries.
    function automatic int inc_lat(input logic [7:0] s);
        return ((s[3:0] == 4'd9) && (s != 8'h99)) ? 4 : 3;
    endfunction

    // One increment for player p in vblank; checks latency, ack and score.
    task automatic do_inc(input int p);
        logic [7:0] exp_s;
        int         exp_lat;
        int         n;
        exp_s   = bcd_inc(sc_m[p]);
        exp_lat = inc_lat(sc_m[p]);
        vpos    = 9'd250;
        inc_req = 2'(1 << p);
        step();
        inc_req = 2'b00;
        n = 1;
        while (inc_ack == 2'b00 && n < 20) begin
            step();
            n++;
        end
        chk($sformatf("inc_latency_p%0d", p), 32'(n), 32'(exp_lat));
        chk($sformatf("inc_ack_p%0d", p), 32'(inc_ack), 32'(1 << p));
        chk($sformatf("inc_score_p%0d", p), 32'(score_of(p)), 32'(exp_s));
        sc_m[p] = exp_s;
        step();
    endtask

    initial begin
        int   n;
        int   t0;
        int   t1;
        int   acks;
        logic bad;
        exp_t e;

        vecs[0]  = '{9'h040, 9'd20, 1'b1, 4'h4, 3'd2, 3'd0, 1'b1};
        vecs[1]  = '{9'h050, 9'd20, 1'b1, 4'h7, 3'd2, 3'd0, 1'b1};
        vecs[2]  = '{9'h000, 9'd20, 1'b1, 4'hF, 3'd2, 3'd0, 1'b1};
        vecs[3]  = '{9'h010, 9'd20, 1'b1, 4'h5, 3'd2, 3'd0, 1'b1};
        vecs[4]  = '{9'h045, 9'd40, 1'b0, 4'hF, 3'd4, 3'd2, 1'b0};
        vecs[5]  = '{9'h020, 9'd20, 1'b1, 4'hF, 3'd2, 3'd0, 1'b1};
        vecs[6]  = '{9'h140, 9'd20, 1'b1, 4'hF, 3'd2, 3'd0, 1'b1};
        vecs[7]  = '{9'h05E, 9'd31, 1'b1, 4'h7, 3'd7, 3'd7, 1'b1};
        vecs[8]  = '{9'h04F, 9'd16, 1'b1, 4'h4, 3'd0, 3'd7, 1'b1};
        vecs[9]  = '{9'h060, 9'd20, 1'b0, 4'hF, 3'd2, 3'd0, 1'b0};
        vecs[10] = '{9'h01A, 9'd15, 1'b1, 4'hF, 3'd7, 3'd5, 1'b1};
        vecs[11] = '{9'h01D, 9'd17, 1'b1, 4'h5, 3'd0, 3'd6, 1'b1};

        sc_m[0] = 8'h00;
        sc_m[1] = 8'h00;

        // Reset held mid-frame with busy inputs.
        reset      = 1'b0;
        hpos       = 9'h045;
        vpos       = 9'd20;
        display_on = 1'b1;
        inc_req    = 2'b11;
        clr        = 1'b0;
        step();
        step();
        chk("rst_digit", 32'(digit), 32'hF);
        chk("rst_line", 32'(line), 32'd0);
        chk("rst_xofs", 32'(xofs), 32'd0);
        chk("rst_pix_en", 32'(pix_en), 32'd0);
        chk("rst_ack", 32'(inc_ack), 32'd0);
        chk("rst_drop", 32'(inc_drop), 32'd0);
        chk("rst_score0", 32'(score0), 32'd0);
        chk("rst_score1", 32'(score1), 32'd0);

        // Release outside the band: blank until the band is reached.
        inc_req = 2'b00;
        vpos    = 9'd100;
        hpos    = 9'h010;
        reset   = 1'b1;
        step();
        step();
        chk("post_rst_digit_outside_band", 32'(digit), 32'hF);
        vpos = 9'd20;
        step();
        chk("post_rst_digit_in_band", 32'(digit), 32'h0);

        // Request in active scan waits for vblank; ack 2 cycles after IDLE sees it.
        vpos    = 9'd100;
        inc_req = 2'b01;
        step();
        inc_req = 2'b00;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            vpos = (i < 5) ? 9'd100 : 9'd239;
            step();
            if (score0 != 8'h00 || inc_ack != 2'b00) bad = 1'b1;
        end
        chk("no_update_before_vblank", 32'(bad), 32'd0);
        vpos = 9'd240;
        n = 0;
        while (inc_ack == 2'b00 && n < 20) begin
            step();
            n++;
        end
        chk("vblank_to_ack_latency", 32'(n), 32'd2);
        chk("single_ack", 32'(inc_ack), 32'b01);
        chk("single_score0", 32'(score0), 32'h01);
        sc_m[0] = 8'h01;
        step();

        // Climb to 09, then a carry to 10.
        for (int i = 0; i < 9; i++) do_inc(0);
        chk("carry_score0", 32'(score0), 32'h10);

        // Repeat request while pending is coalesced into one increment.
        vpos    = 9'd100;
        inc_req = 2'b01;
        step();
        step();
        chk("drop_pulse", 32'(inc_drop), 32'b01);
        inc_req = 2'b00;
        step();
        chk("drop_one_cycle", 32'(inc_drop), 32'b00);
        vpos = 9'd250;
        acks = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (inc_ack[0]) acks++;
        end
        chk("coalesced_ack_count", 32'(acks), 32'd1);
        sc_m[0] = bcd_inc(sc_m[0]);
        chk("coalesced_score0", 32'(score0), 32'(sc_m[0]));

        // Arbitration: put rr at 0, then two simultaneous rounds.
        do_inc(1);
        for (int rep = 0; rep < 2; rep++) begin
            vpos    = 9'd250;
            inc_req = 2'b11;
            step();
            inc_req = 2'b00;
            t0 = -1;
            t1 = -1;
            for (int k = 1; k <= 14; k++) begin
                if (inc_ack[0] && t0 < 0) t0 = k;
                if (inc_ack[1] && t1 < 0) t1 = k;
                step();
            end
            chk($sformatf("arb_p0_first_r%0d", rep), 32'(t0), 32'(inc_lat(sc_m[0])));
            chk($sformatf("arb_p1_after_r%0d", rep), 32'(t1),
                32'(inc_lat(sc_m[0]) + inc_lat(sc_m[1])));
            sc_m[0] = bcd_inc(sc_m[0]);
            sc_m[1] = bcd_inc(sc_m[1]);
            chk($sformatf("arb_score0_r%0d", rep), 32'(score0), 32'(sc_m[0]));
            chk($sformatf("arb_score1_r%0d", rep), 32'(score1), 32'(sc_m[1]));
        end

        // Clear while in ONES: no ack, scores and pending zeroed.
        vpos    = 9'd250;
        inc_req = 2'b10;
        step();
        inc_req = 2'b00;
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_score0", 32'(score0), 32'd0);
        chk("clr_score1", 32'(score1), 32'd0);
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            if (inc_ack != 2'b00) acks++;
            step();
        end
        chk("clr_no_ack", 32'(acks), 32'd0);
        sc_m[0] = 8'h00;
        sc_m[1] = 8'h00;

        // Clear wins over a same-cycle request: no drop, nothing pending.
        clr     = 1'b1;
        inc_req = 2'b11;
        step();
        clr     = 1'b0;
        inc_req = 2'b00;
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            if (inc_ack != 2'b00 || inc_drop != 2'b00) acks++;
            step();
        end
        chk("clr_req_discarded", 32'(acks), 32'd0);

        // Reset during TENS aborts without ack; score restarts at 00.
        for (int i = 0; i < 9; i++) do_inc(0);
        vpos    = 9'd250;
        inc_req = 2'b01;
        step();
        inc_req = 2'b00;
        step();
        step();
        reset = 1'b0;
        #1;
        chk("tens_rst_score0", 32'(score0), 32'd0);
        chk("tens_rst_ack", 32'(inc_ack), 32'd0);
        chk("tens_rst_pix_en", 32'(pix_en), 32'd0);
        step();
        reset = 1'b1;
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (inc_ack != 2'b00) acks++;
        end
        chk("tens_rst_no_ack", 32'(acks), 32'd0);
        sc_m[0] = 8'h00;
        sc_m[1] = 8'h00;
        do_inc(0);

        // Build score0 = 05, score1 = 47 for the digit map.
        for (int i = 0; i < 4; i++) do_inc(0);
        for (int i = 0; i < 47; i++) do_inc(1);
        chk("map_setup_score0", 32'(score0), 32'h05);
        chk("map_setup_score1", 32'(score1), 32'h47);

        // Render vectors: push expected on drive, pop and compare one cycle later.
        for (int i = 0; i < 12; i++) begin
            hpos       = vecs[i].hpos;
            vpos       = vecs[i].vpos;
            display_on = vecs[i].on;
            exp_q.push_back('{vecs[i].digit, vecs[i].line, vecs[i].xofs, vecs[i].pix});
            step();
            if (exp_q.size() == 0) begin
                chk($sformatf("map_queue_empty_%0d", i), 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("map_digit_%0d", i), 32'(digit), 32'(e.digit));
                chk($sformatf("map_line_%0d", i), 32'(line), 32'(e.line));
                chk($sformatf("map_xofs_%0d", i), 32'(xofs), 32'(e.xofs));
                chk($sformatf("map_pix_en_%0d", i), 32'(pix_en), 32'(e.pix));
            end
        end
        display_on = 1'b1;

        // Saturation: climb score0 to 99, one more keeps 99 and still acks.
        for (int i = 0; i < 94; i++) do_inc(0);
        chk("sat_reach_99", 32'(score0), 32'h99);
        do_inc(0);
        chk("sat_hold_99", 32'(score0), 32'h99);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
